// File: rtl/filter_pkg.sv
// Shared Q-format constants, default coefficients and saturation limits for the FIR/IIR pair.
package filter_pkg;

  localparam int unsigned Q_DATA_W = 32;
  localparam int unsigned Q_FRAC_W = 16;
  localparam int unsigned Q_NTAPS  = 3;

  // Defaults realise 1 - 0.75z^-1 + 0.25z^-2, the inverse of the all-pole section.
  localparam logic signed [31:0] COEF0_DEF = 32'sh0001_0000;  //  1.0
  localparam logic signed [31:0] COEF1_DEF = 32'shFFFF_4000;  // -0.75
  localparam logic signed [31:0] COEF2_DEF = 32'sh0000_4000;  //  0.25

  // Largest positive two's-complement value of width w (w <= 64).
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width w, as a w-bit pattern.
  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/q_sat_trunc.sv
// Arithmetic shift right by FRAC_W (floor) then saturate to DATA_W bits; purely combinational.
module q_sat_trunc import filter_pkg::*; #(
  parameter int unsigned IN_W   = 2 * Q_DATA_W + 2,
  parameter int unsigned DATA_W = Q_DATA_W,
  parameter int unsigned FRAC_W = Q_FRAC_W
) (
  input  logic signed [IN_W-1:0]   sum_i,
  output logic signed [DATA_W-1:0] data_o,
  output logic                     sat_o
);

  localparam logic [DATA_W-1:0] SatMax = DATA_W'(sat_max(DATA_W));
  localparam logic [DATA_W-1:0] SatMin = DATA_W'(sat_min(DATA_W));

  logic signed [IN_W-1:0]     shifted;
  logic        [IN_W-DATA_W:0] top_bits;

  // In range iff every bit from the result sign bit upward is a copy of the sign.
  always_comb begin
    shifted  = sum_i >>> FRAC_W;
    top_bits = shifted[IN_W-1:DATA_W-1];
    sat_o    = !((&top_bits) || !(|top_bits));
    data_o   = shifted[DATA_W-1:0];
    if (sat_o) begin
      data_o = shifted[IN_W-1] ? SatMin : SatMax;
    end
  end

endmodule

// File: rtl/inverse_fir.sv
// Three-tap Q16.16 FIR, y[n] = c0*x[n] + c1*x[n-1] + c2*x[n-2], two-stage valid/ready pipeline.
module inverse_fir import filter_pkg::*; #(
  parameter int unsigned DATA_W = Q_DATA_W,
  parameter int unsigned FRAC_W = Q_FRAC_W,
  parameter int unsigned NTAPS  = Q_NTAPS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] outTrunc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sat,
  input  logic                     coef_wr,
  input  logic [1:0]               coef_sel,
  input  logic signed [DATA_W-1:0] coef_data,
  input  logic                     flush
);

  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned SumW  = 2 * DATA_W + 2;

  logic signed [DATA_W-1:0] coef_q [NTAPS];
  logic signed [DATA_W-1:0] coef_d [NTAPS];
  logic signed [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d;
  logic signed [ProdW-1:0]  p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     sat_q, sat_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_adv, accept;
  logic signed [SumW-1:0]   sum;
  logic signed [DATA_W-1:0] trunc_data;
  logic                     trunc_sat;

  // Handshake: a stage moves when it is empty or its successor moves; flush blocks input.
  always_comb begin
    out_adv  = !out_valid_q || out_ready;
    in_ready = rst && !flush && (!s1_valid_q || out_adv);
    accept   = in_valid && in_ready;
  end

  // Coefficient writes land on the next edge, so a same-cycle sample still sees the old value.
  always_comb begin
    coef_d = coef_q;
    if (coef_wr) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        if (32'(coef_sel) == i) begin
          coef_d[i] = coef_data;
        end
      end
    end
  end

  // Stage 1: full-width products and the delay line, both updated only on acceptance.
  always_comb begin
    x1_d       = x1_q;
    x2_d       = x2_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    s1_valid_d = s1_valid_q;
    if (flush) begin
      x1_d       = '0;
      x2_d       = '0;
      s1_valid_d = 1'b0;
    end else if (accept) begin
      p0_d       = ProdW'(coef_q[0]) * ProdW'(in);
      p1_d       = ProdW'(coef_q[1]) * ProdW'(x1_q);
      p2_d       = ProdW'(coef_q[2]) * ProdW'(x2_q);
      x1_d       = in;
      x2_d       = x1_q;
      s1_valid_d = 1'b1;
    end else if (out_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Sum is wide enough that three full products can never overflow before the shift.
  always_comb begin
    sum = SumW'(p0_q) + SumW'(p1_q) + SumW'(p2_q);
  end

  q_sat_trunc #(
    .IN_W  (SumW),
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_sat (
    .sum_i (sum),
    .data_o(trunc_data),
    .sat_o (trunc_sat)
  );

  // Stage 2: result register holds steady while the consumer stalls.
  always_comb begin
    out_d       = out_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = trunc_data;
        sat_d = trunc_sat;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        coef_q[i] <= '0;
      end
      coef_q[0]   <= DATA_W'(COEF0_DEF);
      coef_q[1]   <= DATA_W'(COEF1_DEF);
      coef_q[2]   <= DATA_W'(COEF2_DEF);
      x1_q        <= '0;
      x2_q        <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      coef_q      <= coef_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign outTrunc  = out_q;
  assign out_sat   = sat_q;
  assign out_valid = out_valid_q;

endmodule
